// File: rtl/ps2_keydec.sv
// rtl/ps2_keydec.sv - PS/2 keyboard receiver: sync, glitch filter, frame FSM, set-2 make/break decoder.
// Optional PS2_PARITY_CHECK_EN enforces odd parity; without it the parity bit is sampled and ignored.
module ps2_keydec #(
  parameter int FILT_LEN    = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic        CLK_SYS,
  input  logic        RST_N,
  input  logic        PS2_CLK,
  input  logic        PS2_DAT,
  output logic [10:0] PS2_KEY,
  output logic        ERR
);

  localparam logic [3:0]  FILT_MAX = 4'(FILT_LEN - 1);
  localparam logic [19:0] TO_MAX   = 20'(TIMEOUT_CYC - 1);
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_CHECK = 1'b1;
`else
  localparam bit PAR_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Index 0 carries the clock line, index 1 the data line.
  logic [1:0] raw;
  logic [1:0] meta_q;
  logic [1:0] sync_q;
  logic [1:0] filt_q;
  logic [3:0] fcnt_q [2];
  logic       clk_prev_q;
  logic       fall;
  logic       dat;

  state_t      state_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        par_q;
  logic [19:0] to_q;
  logic        ext_q;
  logic        brk_q;
  logic [10:0] key_q;
  logic        err_q;
  logic        par_ok;

  assign raw = {PS2_DAT, PS2_CLK};

  always_ff @(posedge CLK_SYS) begin
    if (!RST_N) begin
      meta_q     <= 2'b11;
      sync_q     <= 2'b11;
      filt_q     <= 2'b11;
      fcnt_q[0]  <= '0;
      fcnt_q[1]  <= '0;
      clk_prev_q <= 1'b1;
    end else begin
      meta_q     <= raw;
      sync_q     <= meta_q;
      clk_prev_q <= filt_q[0];
      // A line flips only after FILT_LEN consecutive samples disagree with it.
      for (int i = 0; i < 2; i++) begin
        if (sync_q[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == FILT_MAX) begin
          filt_q[i] <= sync_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + 4'd1;
        end
      end
    end
  end

  assign fall   = clk_prev_q & ~filt_q[0];
  assign dat    = filt_q[1];
  assign par_ok = !PAR_CHECK || (^{shift_q, par_q});

  always_ff @(posedge CLK_SYS) begin
    if (!RST_N) begin
      state_q <= IDLE;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      to_q    <= '0;
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      key_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (state_q == IDLE) begin
        to_q <= '0;
        if (fall && !dat) begin
          state_q <= DATA;
          bit_q   <= '0;
        end
      end else if (fall) begin
        to_q <= '0;
        case (state_q)
          DATA: begin
            shift_q <= {dat, shift_q[7:1]};
            if (bit_q == 3'd7) state_q <= PARITY;
            else               bit_q   <= bit_q + 3'd1;
          end
          PARITY: begin
            par_q   <= dat;
            state_q <= STOP;
          end
          default: begin
            state_q <= IDLE;
            if (dat && par_ok) begin
              case (shift_q)
                8'hE0: ext_q <= 1'b1;
                8'hF0: brk_q <= 1'b1;
                8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: begin
                  ext_q <= 1'b0;
                  brk_q <= 1'b0;
                end
                default: begin
                  key_q <= {~key_q[10], ~brk_q, ext_q, shift_q};
                  ext_q <= 1'b0;
                  brk_q <= 1'b0;
                end
              endcase
            end else begin
              err_q <= 1'b1;
              ext_q <= 1'b0;
              brk_q <= 1'b0;
            end
          end
        endcase
      end else if (to_q == TO_MAX) begin
        // Line went quiet mid-frame: abandon it and forget any pending prefix.
        state_q <= IDLE;
        to_q    <= '0;
        err_q   <= 1'b1;
        ext_q   <= 1'b0;
        brk_q   <= 1'b0;
      end else begin
        to_q <= to_q + 20'd1;
      end
    end
  end

  assign PS2_KEY = key_q;
  assign ERR     = err_q;

endmodule
